// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
//
// Frame-paced sequencer for the breakout ball. Every movement step it erases
// the ball at its current position, works out the next direction and position
// (wall, ceiling and paddle bounces, bottom-row game over) and then redraws
// the ball. The ball X/Y/direction state lives here, and the shared VGA plot
// port is driven through a request/acknowledge handshake.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   resetn       asynchronous active-low reset
//   start        one-cycle pulse: launch from IDLE, restart from OVER
//   frame_tick   one-cycle pulse: request one movement step
//   paddle_x     paddle left edge (paddle spans paddle_x..paddle_x+PADDLE_W-1)
//   plot_ack     plotter accepted the current pixel
//   plot_req     pixel write request
//   plot_x/y     pixel coordinates
//   plot_colour  pixel colour
//   ball_x/y     current ball position
//   dir          bit0 set = X decreasing, bit1 set = Y decreasing
//   game_over    ball reached the bottom row without a paddle bounce
//   busy         high while erasing, calculating or drawing
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
  parameter int          SCREEN_W    = 160,
  parameter int          SCREEN_H    = 120,
  parameter int          START_X     = 80,
  parameter int          START_Y     = 60,
  parameter logic [1:0]  START_DIR   = 2'b00,
  parameter int          PADDLE_Y    = 110,
  parameter int          PADDLE_W    = 16,
  parameter logic [2:0]  BALL_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       frame_tick,
  input  logic [9:0] paddle_x,
  input  logic       plot_ack,
  output logic       plot_req,
  output logic [9:0] plot_x,
  output logic [9:0] plot_y,
  output logic [2:0] plot_colour,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] dir,
  output logic       game_over,
  output logic       busy
);

  localparam logic [9:0]  X_MAX       = 10'(SCREEN_W - 1);
  localparam logic [9:0]  Y_MAX       = 10'(SCREEN_H - 1);
  localparam logic [9:0]  PADDLE_ROW  = 10'(PADDLE_Y - 1);
  localparam logic [10:0] PADDLE_SPAN = 11'(PADDLE_W - 1);
  localparam logic [9:0]  START_X_V   = 10'(START_X);
  localparam logic [9:0]  START_Y_V   = 10'(START_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_CALC,
    S_DRAW,
    S_OVER
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  ball_x_q, ball_x_d;
  logic [9:0]  ball_y_q, ball_y_d;
  logic [1:0]  dir_q, dir_d;
  logic        pending_q, pending_d;
  logic        plot_req_q, plot_req_d;
  logic [9:0]  plot_x_q, plot_x_d;
  logic [9:0]  plot_y_q, plot_y_d;
  logic [2:0]  plot_colour_q, plot_colour_d;
  logic        game_over_q, game_over_d;
  logic        busy_q, busy_d;

  logic        x_flip;
  logic        y_flip;
  logic [10:0] paddle_hi;
  logic        on_paddle;
  logic        paddle_hit;
  logic        hit_bottom;
  logic [1:0]  calc_dir;
  logic [9:0]  step_x;
  logic [9:0]  step_y;

  // Collision evaluation on the current position and direction. The paddle
  // right edge is formed at 11 bits so a paddle near the top of the 10-bit
  // range cannot wrap around and appear to cover the left of the screen.
  // The stepped position uses the already-bounced direction, so a ball on a
  // wall or corner moves back into the playfield in the same calculation.
  always_comb begin
    x_flip     = (dir_q[0] && (ball_x_q == 10'd0)) ||
                 (!dir_q[0] && (ball_x_q == X_MAX));
    y_flip     = dir_q[1] && (ball_y_q == 10'd0);
    paddle_hi  = {1'b0, paddle_x} + PADDLE_SPAN;
    on_paddle  = ({1'b0, ball_x_q} >= {1'b0, paddle_x}) &&
                 ({1'b0, ball_x_q} <= paddle_hi);
    paddle_hit = !dir_q[1] && (ball_y_q == PADDLE_ROW) && on_paddle;
    hit_bottom = !dir_q[1] && (ball_y_q == Y_MAX) && !paddle_hit;

    calc_dir[0] = dir_q[0] ^ x_flip;
    if (paddle_hit) begin
      calc_dir[1] = 1'b1;
    end else if (y_flip) begin
      calc_dir[1] = 1'b0;
    end else begin
      calc_dir[1] = dir_q[1];
    end

    step_x = calc_dir[0] ? (ball_x_q - 10'd1) : (ball_x_q + 10'd1);
    step_y = calc_dir[1] ? (ball_y_q - 10'd1) : (ball_y_q + 10'd1);
  end

  // Sequencer next state plus ball/tick bookkeeping. A tick that lands while
  // a step is already in progress is remembered once in pending so it is not
  // lost; ticks are meaningless before launch and after game over.
  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dir_d     = dir_q;
    pending_d = pending_q;

    if (frame_tick && (state_q inside {S_ERASE, S_CALC, S_DRAW})) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRAW;
        end
      end
      S_WAIT: begin
        if (frame_tick || pending_q) begin
          state_d   = S_ERASE;
          pending_d = 1'b0;
        end
      end
      S_ERASE: begin
        if (plot_ack) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        dir_d = calc_dir;
        if (hit_bottom) begin
          state_d = S_OVER;
        end else begin
          ball_x_d = step_x;
          ball_y_d = step_y;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        if (plot_ack) begin
          state_d = S_WAIT;
        end
      end
      S_OVER: begin
        if (start) begin
          ball_x_d = START_X_V;
          ball_y_d = START_Y_V;
          dir_d    = START_DIR;
          state_d  = S_DRAW;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the next state so that plot_req,
  // busy and game_over line up exactly with the state they describe. Plot
  // coordinates are only reloaded while a request is being presented; since
  // the ball does not move during ERASE or DRAW they stay stable until ack.
  always_comb begin
    plot_req_d    = (state_d == S_ERASE) || (state_d == S_DRAW);
    plot_x_d      = plot_x_q;
    plot_y_d      = plot_y_q;
    plot_colour_d = plot_colour_q;
    if (plot_req_d) begin
      plot_x_d      = ball_x_d;
      plot_y_d      = ball_y_d;
      plot_colour_d = (state_d == S_DRAW) ? BALL_COLOUR : BG_COLOUR;
    end
    game_over_d = (state_d == S_OVER);
    busy_d      = state_d inside {S_ERASE, S_CALC, S_DRAW};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      ball_x_q      <= START_X_V;
      ball_y_q      <= START_Y_V;
      dir_q         <= START_DIR;
      pending_q     <= 1'b0;
      plot_req_q    <= 1'b0;
      plot_x_q      <= 10'd0;
      plot_y_q      <= 10'd0;
      plot_colour_q <= 3'd0;
      game_over_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dir_q         <= dir_d;
      pending_q     <= pending_d;
      plot_req_q    <= plot_req_d;
      plot_x_q      <= plot_x_d;
      plot_y_q      <= plot_y_d;
      plot_colour_q <= plot_colour_d;
      game_over_q   <= game_over_d;
      busy_q        <= busy_d;
    end
  end

  assign plot_req    = plot_req_q;
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_colour = plot_colour_q;
  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign dir         = dir_q;
  assign game_over   = game_over_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_ctrl
//
// Drives the ball sequencer through launch, single steps, wall/paddle play,
// game over and restart, stalled acknowledges and reset during a handshake.
// The ball is modelled as a position plus a +1/-1 velocity per axis that
// reflects off walls and the paddle.
// ---------------------------------------------------------------------------
module tb_ball_motion_ctrl;

  localparam int         W    = 160;
  localparam int         H    = 120;
  localparam int         PY   = 110;
  localparam int         PW   = 16;
  localparam logic [2:0] BALL = 3'b111;
  localparam logic [2:0] BG   = 3'b000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       plot_ack = 1'b0;
  logic [9:0] paddle_x = 10'd500;
  logic       plot_req;
  logic [9:0] plot_x;
  logic [9:0] plot_y;
  logic [2:0] plot_colour;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [1:0] dir;
  logic       game_over;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference ball: position and per-axis velocity, paddle left edge.
  int mx, my, mdx, mdy, px;

  ball_motion_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .frame_tick (frame_tick),
    .paddle_x   (paddle_x),
    .plot_ack   (plot_ack),
    .plot_req   (plot_req),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_colour(plot_colour),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .dir        (dir),
    .game_over  (game_over),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_restart();
    mx  = 80;
    my  = 60;
    mdx = 1;
    mdy = 1;
  endtask

  function automatic logic [1:0] model_dir();
    return {(mdy < 0), (mdx < 0)};
  endfunction

  // One movement step of the ideal ball; returns 1 when the ball is lost.
  function automatic bit model_step();
    int  nx = mdx;
    int  ny = mdy;
    bit  bounce;
    bit  lost;
    if ((mdx < 0 && mx == 0) || (mdx > 0 && mx == W - 1)) nx = -mdx;
    if (mdy < 0 && my == 0) ny = 1;
    bounce = (mdy > 0) && (my == PY - 1) && (mx >= px) && (mx <= px + PW - 1);
    if (bounce) ny = -1;
    lost = (mdy > 0) && (my == H - 1) && !bounce;
    mdx = nx;
    mdy = ny;
    if (lost) return 1'b1;
    mx = mx + nx;
    my = my + ny;
    return 1'b0;
  endfunction

  // Serve one plot request: wait for it, check it, stall the ack for
  // 'delay' cycles (optionally injecting ticks) and check it drops after ack.
  task automatic serve_plot(input int delay, input int mask, input int ex,
                            input int ey, input logic [2:0] ec, input string tag);
    int n = 0;
    while (plot_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (plot_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_req: plot_req=%b, want 1 within 10 cycles", tag, plot_req);
      return;
    end
    checks++;
    if (plot_x !== 10'(ex) || plot_y !== 10'(ey) || plot_colour !== ec) begin
      errors++;
      $display("[TB] FAIL %s_pixel: got (%0d,%0d) c=%0d, want (%0d,%0d) c=%0d",
               tag, plot_x, plot_y, plot_colour, ex, ey, ec);
    end
    for (int i = 0; i < delay; i++) begin
      plot_ack   = 1'b0;
      frame_tick = mask[i];
      @(negedge clk);
      frame_tick = 1'b0;
      checks++;
      if (plot_req !== 1'b1 || plot_x !== 10'(ex) || plot_y !== 10'(ey) || plot_colour !== ec) begin
        errors++;
        $display("[TB] FAIL %s_stable: req=%b (%0d,%0d) c=%0d, want req=1 (%0d,%0d) c=%0d",
                 tag, plot_req, plot_x, plot_y, plot_colour, ex, ey, ec);
      end
    end
    plot_ack = 1'b1;
    @(negedge clk);
    plot_ack = 1'b0;
    checks++;
    if (plot_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_drop: plot_req=%b after ack, want 0", tag, plot_req);
    end
  endtask

  // Launch (from IDLE) or restart (from OVER) and serve the initial draw.
  task automatic do_launch();
    model_restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (plot_req !== 1'b1 || busy !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("[TB] FAIL launch_entry: req=%b busy=%b over=%b, want 1 1 0",
               plot_req, busy, game_over);
    end
    serve_plot(0, 0, 80, 60, BALL, "launch");
    checks++;
    if (ball_x !== 10'd80 || ball_y !== 10'd60 || dir !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL launch_ball: got (%0d,%0d) dir=%b busy=%b, want (80,60) dir=00 busy=0",
               ball_x, ball_y, dir, busy);
    end
  endtask

  // One full movement step starting in WAIT, either by a fresh tick or a
  // pending one. Ticks selected by mask are injected during the erase stall.
  task automatic do_step(input bit use_tick, input int delay, input int mask, output bit over);
    int ox, oy;
    paddle_x = 10'(px);
    if (use_tick) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end else begin
      @(negedge clk);
    end
    checks++;
    if (plot_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL step_start: req=%b busy=%b, want 1 1", plot_req, busy);
    end
    ox   = mx;
    oy   = my;
    over = model_step();
    serve_plot(delay, mask, ox, oy, BG, "erase");
    if (over) begin
      @(negedge clk);
      checks++;
      if (game_over !== 1'b1 || ball_x !== 10'(ox) || ball_y !== 10'(oy) ||
          busy !== 1'b0 || plot_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL over_entry: over=%b (%0d,%0d) busy=%b req=%b, want 1 (%0d,%0d) 0 0",
                 game_over, ball_x, ball_y, busy, plot_req, ox, oy);
      end
    end else begin
      serve_plot(0, 0, mx, my, BALL, "draw");
      checks++;
      if (ball_x !== 10'(mx) || ball_y !== 10'(my) || dir !== model_dir() ||
          busy !== 1'b0 || game_over !== 1'b0) begin
        errors++;
        $display("[TB] FAIL step_ball: got (%0d,%0d) dir=%b busy=%b over=%b, want (%0d,%0d) dir=%b 0 0",
                 ball_x, ball_y, dir, busy, game_over, mx, my, model_dir());
      end
    end
  endtask

  // Wait some cycles and confirm nothing new was started.
  task automatic expect_quiet(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) @(negedge clk);
    checks++;
    if (plot_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: req=%b busy=%b, want 0 0", tag, plot_req, busy);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (plot_req !== 1'b0 || plot_x !== 10'd0 || plot_y !== 10'd0 || plot_colour !== 3'd0 ||
        ball_x !== 10'd80 || ball_y !== 10'd60 || dir !== 2'b00 ||
        game_over !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: req=%b plot=(%0d,%0d,%0d) ball=(%0d,%0d) dir=%b over=%b busy=%b, want all zero, ball (80,60)",
               plot_req, plot_x, plot_y, plot_colour, ball_x, ball_y, dir, game_over, busy);
    end
    resetn = 1'b1;
    model_restart();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    expect_quiet(2, "idle_tick_ignored");
  endtask

  task automatic test_launch();
    do_launch();
    expect_quiet(3, "launch_no_pending");
  endtask

  // Ack held high: ERASE, CALC, DRAW, WAIT on consecutive cycles.
  task automatic test_step_timing();
    bit dummy;
    px       = 500;
    paddle_x = 10'(px);
    plot_ack   = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if (plot_req !== 1'b1 || busy !== 1'b1 || plot_colour !== BG ||
        plot_x !== 10'd80 || plot_y !== 10'd60) begin
      errors++;
      $display("[TB] FAIL timing_erase: req=%b busy=%b (%0d,%0d) c=%0d, want 1 1 (80,60) c=0",
               plot_req, busy, plot_x, plot_y, plot_colour);
    end
    dummy = model_step();
    @(negedge clk);
    checks++;
    if (plot_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timing_calc: req=%b busy=%b, want 0 1", plot_req, busy);
    end
    @(negedge clk);
    checks++;
    if (plot_req !== 1'b1 || plot_colour !== BALL || plot_x !== 10'(mx) || plot_y !== 10'(my) ||
        ball_x !== 10'(mx) || ball_y !== 10'(my) || dir !== model_dir()) begin
      errors++;
      $display("[TB] FAIL timing_draw: req=%b (%0d,%0d) c=%0d ball=(%0d,%0d) dir=%b, want 1 (%0d,%0d) c=7 dir=%b",
               plot_req, plot_x, plot_y, plot_colour, ball_x, ball_y, dir, mx, my, model_dir());
    end
    @(negedge clk);
    checks++;
    if (plot_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timing_wait: req=%b busy=%b, want 0 0", plot_req, busy);
    end
    expect_quiet(2, "ack_in_wait_ignored");
    plot_ack = 1'b0;
  endtask

  // Random play: paddle usually placed under the ball near its edges,
  // sometimes missing; random ack delays; restart after each loss.
  task automatic test_random_play();
    bit over;
    for (int i = 0; i < 250; i++) begin
      if (my == PY - 1 && mdy > 0 && $urandom_range(0, 7) != 0) begin
        int off = int'($urandom_range(0, 17));
        px = (mx >= off) ? (mx - off) : 0;
      end else begin
        px = int'($urandom_range(0, 1023));
      end
      do_step(1'b1, int'($urandom_range(0, 3)), 0, over);
      if (over) do_launch();
    end
  endtask

  // Paddle far away: play to the bottom, then check OVER and restart.
  task automatic test_game_over();
    bit over = 1'b0;
    int n = 0;
    px = 600;
    while (!over && n < 300) begin
      do_step(1'b1, 0, 0, over);
      n++;
    end
    checks++;
    if (!over) begin
      errors++;
      $display("[TB] FAIL over_reached: no game over after %0d steps, want one", n);
      return;
    end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    expect_quiet(3, "over_tick_ignored");
    checks++;
    if (game_over !== 1'b1) begin
      errors++;
      $display("[TB] FAIL over_hold: game_over=%b, want 1", game_over);
    end
    do_launch();
    expect_quiet(3, "restart_no_pending");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_quiet(3, "start_in_wait_ignored");
    checks++;
    if (ball_x !== 10'd80 || ball_y !== 10'd60) begin
      errors++;
      $display("[TB] FAIL start_in_wait_ball: got (%0d,%0d), want (80,60)", ball_x, ball_y);
    end
  endtask

  // Ack stalled 10 cycles with 3 ticks: exactly one extra step follows.
  task automatic test_back_to_back();
    bit over;
    px = 600;
    do_step(1'b1, 10, 32'h0000_0092, over);
    do_step(1'b0, 0, 0, over);
    expect_quiet(4, "extra_ticks_dropped");
  endtask

  task automatic test_reset_mid_handshake();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    resetn = 1'b0;
    #1;
    checks++;
    if (plot_req !== 1'b0 || busy !== 1'b0 || ball_x !== 10'd80 || ball_y !== 10'd60) begin
      errors++;
      $display("[TB] FAIL reset_mid: req=%b busy=%b ball=(%0d,%0d), want 0 0 (80,60)",
               plot_req, busy, ball_x, ball_y);
    end
    @(negedge clk);
    resetn = 1'b1;
    expect_quiet(2, "reset_mid_idle");
    do_launch();
  endtask

  initial begin
    test_reset();
    test_launch();
    test_step_timing();
    test_random_play();
    test_game_over();
    test_back_to_back();
    test_reset_mid_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
